// File: rtl/sort_pkg.sv
// Shared types and defaults for the sorted frame reader.
// Contents:
//   SORT_WIDTH, SORT_N  default element width and elements per frame
//   elem_t              one element of the default width
//   rd_state_t          reader FSM states
package sort_pkg;

    localparam int SORT_WIDTH = 8;
    localparam int SORT_N     = 8;

    typedef logic [SORT_WIDTH-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SEND
    } rd_state_t;

endpackage

// File: rtl/order_check.sv
// Combinational order checker.
// It compares each pair of adjacent elements of the captured frame.
// Ports:
//   elems      in   N x WIDTH  captured frame; elems[0] is expected to be the smallest
//   unordered  out  1          high if any elems[i] > elems[i+1] (unsigned compare)
// Equal neighbours count as ordered.
module order_check #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic [WIDTH-1:0] elems [N],
    output logic             unordered
);

    always_comb begin
        unordered = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (elems[i] > elems[i+1]) begin
                unordered = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sorted_frame_reader.sv
// Sorted frame reader.
// It accepts one parallel frame of N sorted elements and checks that the frame is
// non-decreasing. It then streams the elements out one per beat.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    parallel frame handshake; in_data element i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready  byte stream handshake
//   out_data, out_idx    current element and its index
//   out_last             high on the beat with out_idx == N-1
//   out_err              order check failed; constant across the frame
//   frame_cnt, err_cnt   saturating counters of streamed frames and of errored frames
//                        (present only when SORT_STATS_EN is defined)
// State table:
//   IDLE  | waiting for a frame, in_ready high
//   CHECK | one cycle to register the order check result
//   SEND  | streaming buffer[idx], idx advances on each accepted beat
import sort_pkg::*;

module sorted_frame_reader #(
    parameter int WIDTH = SORT_WIDTH,
    parameter int N     = SORT_N,
    localparam int IDXW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDXW-1:0]    out_idx,
    output logic               out_last,
    output logic               out_err
`ifdef SORT_STATS_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        err_cnt
`endif
);

    rd_state_t         state_q, state_d;
    logic [WIDTH-1:0]  frame_q [N];
    logic [IDXW-1:0]   idx_q;
    logic              err_q;
    logic              unordered;
    logic              in_fire;
    logic              out_fire;
    logic              last_beat;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_beat = (idx_q == IDXW'(N - 1));
    assign out_idx   = idx_q;

    order_check #(.WIDTH(WIDTH), .N(N)) u_order_check (
        .elems     (frame_q),
        .unordered (unordered)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The stream outputs are forced to zero outside SEND.
    // This keeps idle outputs at their reset values after a frame has been streamed.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = frame_q[idx_q];
                out_last  = last_beat;
                out_err   = err_q;
                if (out_ready && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                frame_q[i] <= '0;
            end
        end else if (in_fire) begin
            for (int i = 0; i < N; i++) begin
                frame_q[i] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == CHECK) begin
            idx_q <= '0;
            err_q <= unordered;
        end else if (out_fire) begin
            idx_q <= last_beat ? '0 : idx_q + IDXW'(1);
        end
    end

`ifdef SORT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (out_fire && last_beat) begin
            if (frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (err_q && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
